// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver: synchronizes the device clock/data, deframes 11-bit frames, queues scan codes.
// Optional PS2_PARITY_CHECK_EN: when defined, frames with bad odd parity are rejected.
module ps2_keyboard #(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
`ifdef PS2_PARITY_CHECK_EN
  localparam int unsigned SW = 9;
`else
  localparam int unsigned SW = 8;
`endif

  typedef enum logic {IDLE, RECV} state_t;

  state_t          state, state_next;
  logic [2:0]      clk_sync;
  logic [1:0]      dat_sync;
  logic [3:0]      bit_cnt;
  logic [TW-1:0]   tmo_cnt;
  logic [SW-1:0]   shift_reg;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [7:0]      mem [FIFO_DEPTH];

  logic fall_c, din_c, tmo_hit_c;
  logic frame_done_c, timeout_c, parity_ok_c, frame_ok_c, frame_bad_c;
  logic empty_c, full_c, pop_c, push_c, drop_c;

  // Synchronizers; idle-high lines reset to 1 so reset release never fakes an edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync <= 3'b111;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[1:0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
    end
  end

  assign fall_c    = clk_sync[2] & ~clk_sync[1];
  assign din_c     = dat_sync[1];
  assign tmo_hit_c = (tmo_cnt == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (fall_c && !din_c) state_next = RECV;
      RECV: begin
        if (fall_c) begin
          if (bit_cnt == 4'd10) state_next = IDLE;
        end else if (tmo_hit_c) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    frame_done_c = 1'b0;
    timeout_c    = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    parity_ok_c  = ^shift_reg;
`else
    parity_ok_c  = 1'b1;
`endif
    if (state == RECV) begin
      frame_done_c = fall_c && (bit_cnt == 4'd10);
      timeout_c    = !fall_c && tmo_hit_c;
    end
    frame_ok_c  = frame_done_c && din_c && parity_ok_c;
    frame_bad_c = (frame_done_c && !(din_c && parity_ok_c)) || timeout_c;
  end

  // Bit counter, timeout counter and shifter; the start bit falls off the low end of the shifter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt   <= 4'd0;
      tmo_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      if (state == IDLE) begin
        bit_cnt <= (fall_c && !din_c) ? 4'd1 : 4'd0;
      end else if (fall_c) begin
        bit_cnt <= (bit_cnt == 4'd10) ? 4'd0 : bit_cnt + 4'd1;
      end else if (timeout_c) begin
        bit_cnt <= 4'd0;
      end

      if (state == IDLE || fall_c) tmo_cnt <= '0;
      else if (!tmo_hit_c)         tmo_cnt <= tmo_cnt + TW'(1);

      if (fall_c && (bit_cnt <= 4'(SW))) shift_reg <= {din_c, shift_reg[SW-1:1]};
    end
  end

  assign empty_c = (wr_ptr == rd_ptr);
  assign full_c  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign pop_c   = !nextdata_n && !empty_c;
  assign push_c  = frame_ok_c && (!full_c || pop_c);
  assign drop_c  = frame_ok_c && full_c && !pop_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 8'h00;
    end else if (push_c) begin
      mem[wr_ptr[AW-1:0]] <= shift_reg[7:0];
    end
  end

  // Pointers and status flags; a drop sets overflow ahead of any clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PW'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PW'(1);
      if (drop_c)     overflow <= 1'b1;
      else if (pop_c) overflow <= 1'b0;
      frame_err <= frame_bad_c;
    end
  end

  assign ready = !empty_c;
  assign data  = mem[rd_ptr[AW-1:0]];

endmodule

// File: doc/ps2_keyboard.md
PS2_KEYBOARD -- requirements
Module: ps2_keyboard

Interface
REQ-001 Parameter FIFO_DEPTH, 8, scan-code FIFO capacity in entries; power of two, 2..64.
REQ-002 Parameter TIMEOUT_CYCLES, 100000, clk cycles without a ps2_clk falling edge before a partial frame is abandoned.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 ps2_clk  input  1  raw PS/2 device clock, asynchronous to clk, idle high.
REQ-006 ps2_data  input  1  raw PS/2 device data, asynchronous to clk, idle high.
REQ-007 nextdata_n  input  1  active-low read strobe; one FIFO entry is consumed per clk cycle it is low while ready=1.
REQ-008 data  output  8  scan code at FIFO head; valid only while ready=1; feeds the seven-segment display stage.
REQ-009 ready  output  1  high while the FIFO holds at least one entry.
REQ-010 overflow  output  1  sticky flag; a completed valid frame was dropped because the FIFO was full.
REQ-011 frame_err  output  1  one-cycle pulse per rejected or abandoned frame.

Function
REQ-012 ps2_clk passes through a 3-flop synchronizer and ps2_data through a 2-flop synchronizer; falling edge = previous synchronized ps2_clk 1, current 0.
REQ-013 On each detected falling edge, synchronized ps2_data is shifted in LSB-first and the 4-bit bit counter increments; frame = start(0), 8 data bits, odd parity, stop(1).
REQ-014 Receiver states: IDLE (count 0), RECV (count 1..10); IDLE->RECV on a falling edge sampling start=0; a start bit sampled as 1 is ignored and the receiver stays IDLE.
REQ-015 On the 11th edge the frame is checked: stop=1 and (per REQ-026) parity; pass -> push, fail -> frame_err pulse, no push; counter returns to 0 in both cases.
REQ-016 Push latency: ready and data valid on the clk cycle after the cycle in which the 11th falling edge is detected.
REQ-017 FIFO pointers are log2(FIFO_DEPTH)+1 bits; wrap modulo 2*FIFO_DEPTH; full = indices equal and MSBs differ; empty = pointers equal.
REQ-018 data = entry at read pointer, combinational from FIFO storage; contents are not cleared on read.
REQ-019 nextdata_n low while empty is ignored; pointers unchanged.
REQ-020 Push while full with no simultaneous pop: frame dropped, overflow set, stored entries unchanged.
REQ-021 Push and pop in the same cycle while full: both occur, overflow unchanged.
REQ-022 overflow clears on the first cycle a pop occurs, except when REQ-020 also occurs in that cycle, in which case set takes priority.
REQ-023 Timeout counter resets on each falling edge and holds at 0 in IDLE; in RECV, reaching TIMEOUT_CYCLES returns the bit counter to 0 and pulses frame_err.

Reset
REQ-024 rst low asynchronously forces: bit counter 0, timeout counter 0, shift register 0, both FIFO pointers 0, FIFO storage 0, synchronizer flops 1, ready 0, data 8'h00, overflow 0, frame_err 0.
REQ-025 Reset asserted mid-frame discards the partial frame; after release, reception resumes only at the next valid start bit.

Configuration
REQ-026 Macro PS2_PARITY_CHECK_EN defined: odd parity over data+parity bits is required, and a mismatch causes frame_err with no push; undefined: the parity bit is ignored and only start and stop bits are checked.

Verification
REQ-027 Send frame 0x1C (parity 0) -> ready=1, data=8'h1C one cycle after the 11th edge; nextdata_n low 1 cycle -> ready=0.
REQ-028 Send 0xF0 then 0x1C, no reads -> data=8'hF0; one pop -> data=8'h1C; second pop -> ready=0.
REQ-029 Send 9 frames 0x01..0x09 with FIFO_DEPTH=8 and no reads -> overflow=1; 8 pops return 0x01..0x08; first pop clears overflow.
REQ-030 Send 0x1C with parity bit 1 -> with PS2_PARITY_CHECK_EN: one frame_err pulse, ready stays 0; without: ready=1, data=8'h1C.
REQ-031 Send 4 bits then idle TIMEOUT_CYCLES+1 cycles -> one frame_err pulse; following full frame 0x32 -> data=8'h32.
REQ-032 Assert rst after 6 bits of a frame, release, then send 0x5A -> only 0x5A is received, frame_err never pulses.
